// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or bench) and the ahb_slave_mem responder.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hr_data;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        input  hready_out, hresp, hr_data
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        output hready_out, hresp, hr_data
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised memory, with programmable
// wait states on OKAY transfers and a two-cycle ERROR response for illegal ones.
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1
) (
    input logic            hclk,
    input logic            hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int          IDX_W        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int          CNT_W        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [32:0] WINDOW_BYTES = 33'(MEM_DEPTH) * 33'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       addr_q;
    logic              write_q;
    logic [2:0]        size_q;

    logic              can_accept;
    logic              take;
    logic [31:0]       req_offset;
    logic              in_window;
    logic              size_ok;
    logic              legal;

    logic [31:0]       addr_offset_q;
    logic [IDX_W-1:0]  word_idx;
    logic [3:0]        byte_en;

    logic [31:0]       mem [MEM_DEPTH];

    // Decode whether a new address phase is taken this cycle and whether it is legal
    always_comb begin
        can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
        take       = can_accept && bus.hsel && bus.hready_in && bus.htrans[1];
        req_offset = bus.haddr - BASE_ADDR;
        in_window  = (bus.haddr >= BASE_ADDR) && ({1'b0, req_offset} < WINDOW_BYTES);
        size_ok    = (bus.hsize == 3'd0) ||
                     ((bus.hsize == 3'd1) && !bus.haddr[0]) ||
                     ((bus.hsize == 3'd2) && (bus.haddr[1:0] == 2'b00));
        legal      = in_window && size_ok;
    end

    // State register, wait counter and the latched address-phase controls
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
        end else begin
            state <= next_state;
            if (next_state == ST_WAIT && state != ST_WAIT) begin
                wait_cnt <= CNT_W'(WAIT_STATES - 1);
            end else if (state == ST_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (take) begin
                addr_q  <= bus.haddr;
                write_q <= bus.hwrite;
                size_q  <= bus.hsize;
            end
        end
    end

    // Next-state selection, including pipelined accepts out of DATA and ERR2
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (take) begin
                    if (!legal) begin
                        next_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        next_state = ST_WAIT;
                    end else begin
                        next_state = ST_DATA;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = ST_DATA;
                end
            end
            ST_ERR1: next_state = ST_ERR2;
            default: next_state = ST_IDLE;
        endcase
    end

    // Word index and little-endian byte lanes of the transfer in its data phase
    always_comb begin
        addr_offset_q = addr_q - BASE_ADDR;
        word_idx      = IDX_W'(addr_offset_q >> 2);
        byte_en       = 4'b0000;
        case (size_q)
            3'd0:    byte_en[addr_q[1:0]] = 1'b1;
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Commit write lanes at the closing edge of a DATA phase; reset drops the write
    always_ff @(posedge hclk) begin
        if (!hreset && state == ST_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    // Bus response driven from the current state; read data only in a read DATA phase
    always_comb begin
        bus.hready_out = 1'b1;
        bus.hresp      = 2'b00;
        bus.hr_data    = 32'h0;
        case (state)
            ST_WAIT: bus.hready_out = 1'b0;
            ST_DATA: begin
                if (!write_q) begin
                    bus.hr_data = mem[word_idx];
                end
            end
            ST_ERR1: begin
                bus.hready_out = 1'b0;
                bus.hresp      = 2'b01;
            end
            ST_ERR2: bus.hresp = 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three builds (1, 0 and 3 wait states)
// share one stimulus set, with hsel steering each step to one build.
module tb_ahb_slave_mem;

    logic        hclk;
    logic        hreset;
    logic [1:0]  dut_sel;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        obs_ready;
    logic [1:0]  obs_resp;
    logic [31:0] obs_data;

    int assert_count;
    int fail_count;

    ahb_slave_mem_if bus_w1 ();
    ahb_slave_mem_if bus_w0 ();
    ahb_slave_mem_if bus_w3 ();

    ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .MEM_DEPTH(256), .WAIT_STATES(1))
        dut_w1 (.hclk(hclk), .hreset(hreset), .bus(bus_w1));
    ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .MEM_DEPTH(256), .WAIT_STATES(0))
        dut_w0 (.hclk(hclk), .hreset(hreset), .bus(bus_w0));
    ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .MEM_DEPTH(256), .WAIT_STATES(3))
        dut_w3 (.hclk(hclk), .hreset(hreset), .bus(bus_w3));

    assign bus_w1.hsel      = hsel && (dut_sel == 2'd0);
    assign bus_w1.haddr     = haddr;
    assign bus_w1.htrans    = htrans;
    assign bus_w1.hwrite    = hwrite;
    assign bus_w1.hsize     = hsize;
    assign bus_w1.hburst    = 3'b001;
    assign bus_w1.hwdata    = hwdata;
    assign bus_w1.hready_in = bus_w1.hready_out;

    assign bus_w0.hsel      = hsel && (dut_sel == 2'd1);
    assign bus_w0.haddr     = haddr;
    assign bus_w0.htrans    = htrans;
    assign bus_w0.hwrite    = hwrite;
    assign bus_w0.hsize     = hsize;
    assign bus_w0.hburst    = 3'b001;
    assign bus_w0.hwdata    = hwdata;
    assign bus_w0.hready_in = bus_w0.hready_out;

    assign bus_w3.hsel      = hsel && (dut_sel == 2'd2);
    assign bus_w3.haddr     = haddr;
    assign bus_w3.htrans    = htrans;
    assign bus_w3.hwrite    = hwrite;
    assign bus_w3.hsize     = hsize;
    assign bus_w3.hburst    = 3'b001;
    assign bus_w3.hwdata    = hwdata;
    assign bus_w3.hready_in = bus_w3.hready_out;

    assign obs_ready = (dut_sel == 2'd0) ? bus_w1.hready_out :
                       (dut_sel == 2'd1) ? bus_w0.hready_out : bus_w3.hready_out;
    assign obs_resp  = (dut_sel == 2'd0) ? bus_w1.hresp :
                       (dut_sel == 2'd1) ? bus_w0.hresp : bus_w3.hresp;
    assign obs_data  = (dut_sel == 2'd0) ? bus_w1.hr_data :
                       (dut_sel == 2'd1) ? bus_w0.hr_data : bus_w3.hr_data;

    // Free-running bus clock
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic applyStimulus(input logic sel_b, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        hsel   = sel_b;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hwdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic exp_ready, input logic [1:0] exp_resp,
                               input logic [31:0] exp_data);
        @(negedge hclk);
        assert_count++;
        assert (obs_ready === exp_ready) else begin
            fail_count++;
            $error("[TB] FAIL %s hready_out got %0b expected %0b", tag, obs_ready, exp_ready);
        end
        assert_count++;
        assert (obs_resp === exp_resp) else begin
            fail_count++;
            $error("[TB] FAIL %s hresp got %0b expected %0b", tag, obs_resp, exp_resp);
        end
        assert_count++;
        assert (obs_data === exp_data) else begin
            fail_count++;
            $error("[TB] FAIL %s hr_data got %08h expected %08h", tag, obs_data, exp_data);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic busCycle(input string tag, input logic sel_b, input logic [1:0] trans,
                            input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic exp_ready,
                            input logic [1:0] exp_resp, input logic [31:0] exp_data);
        applyStimulus(sel_b, trans, addr, wr, size, wdata);
        checkOutput(tag, exp_ready, exp_resp, exp_data);
        tick();
    endtask

    task automatic doXfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int n_wait);
        busCycle({tag, "/addr"}, 1'b1, 2'b10, addr, wr, size, 32'h0, 1'b1, 2'b00, 32'h0);
        for (int i = 0; i < n_wait; i++) begin
            busCycle({tag, "/wait"}, 1'b1, 2'b00, addr, wr, size, wdata, 1'b0, 2'b00, 32'h0);
        end
        busCycle({tag, "/data"}, 1'b1, 2'b00, addr, wr, size, wdata, 1'b1, 2'b00,
                 wr ? 32'h0 : exp_rdata);
    endtask

    task automatic errXfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size);
        busCycle({tag, "/addr"}, 1'b1, 2'b10, addr, wr, size, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle({tag, "/err1"}, 1'b1, 2'b00, addr, wr, size, 32'hFFFF_FFFF, 1'b0, 2'b01, 32'h0);
        busCycle({tag, "/err2"}, 1'b1, 2'b00, addr, wr, size, 32'hFFFF_FFFF, 1'b1, 2'b01, 32'h0);
    endtask

    // Directed sequence covering reset, data paths, pipelining, errors and reset abort
    initial begin
        assert_count = 0;
        fail_count   = 0;
        dut_sel      = 2'd0;
        hreset       = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
        tick();
        checkOutput("reset", 1'b1, 2'b00, 32'h0);
        tick();
        hreset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            busCycle("idle", 1'b1, 2'b00, 32'h8000_0000, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        end

        // One wait state build: word clear, byte write, readback
        doXfer("w0_clear", 1'b1, 32'h8000_0000, 3'd2, 32'h0000_0000, 32'h0, 1);
        doXfer("byte_wr", 1'b1, 32'h8000_0001, 3'd0, 32'h0000_AB00, 32'h0, 1);
        doXfer("byte_rd", 1'b0, 32'h8000_0000, 3'd2, 32'h0, 32'h0000_AB00, 1);

        // Halfword into the upper lanes of a known word
        doXfer("w1_init", 1'b1, 32'h8000_0004, 3'd2, 32'h1111_1111, 32'h0, 1);
        doXfer("half_wr", 1'b1, 32'h8000_0006, 3'd1, 32'hCAFE_0000, 32'h0, 1);
        doXfer("half_rd", 1'b0, 32'h8000_0004, 3'd2, 32'h0, 32'hCAFE_1111, 1);

        // Unselected NONSEQ is ignored
        busCycle("nosel", 1'b0, 2'b10, 32'h8000_0000, 1'b1, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("nosel_next", 1'b0, 2'b00, 32'h8000_0000, 1'b1, 3'd2, 32'h5555_5555, 1'b1, 2'b00, 32'h0);

        // Back-to-back write then read of the same word
        busCycle("b2b_wr_addr", 1'b1, 2'b10, 32'h8000_0010, 1'b1, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("b2b_wr_wait", 1'b1, 2'b00, 32'h8000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0);
        busCycle("b2b_wr_data", 1'b1, 2'b10, 32'h8000_0010, 1'b0, 3'd2, 32'hDEAD_BEEF, 1'b1, 2'b00, 32'h0);
        busCycle("b2b_rd_wait", 1'b1, 2'b00, 32'h8000_0010, 1'b0, 3'd2, 32'h0, 1'b0, 2'b00, 32'h0);
        busCycle("b2b_rd_data", 1'b1, 2'b00, 32'h8000_0010, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'hDEAD_BEEF);

        // Error responses
        errXfer("oor_wr", 1'b1, 32'h8000_0400, 3'd2);
        errXfer("half_odd", 1'b1, 32'h8000_0005, 3'd1);
        errXfer("size3", 1'b0, 32'h8000_0008, 3'd3);
        errXfer("below_base", 1'b0, 32'h7FFF_FFFC, 3'd2);
        busCycle("mis_addr", 1'b1, 2'b10, 32'h8000_0002, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("mis_err1", 1'b1, 2'b00, 32'h8000_0002, 1'b0, 3'd2, 32'h0, 1'b0, 2'b01, 32'h0);
        busCycle("mis_err2", 1'b1, 2'b10, 32'h8000_0000, 1'b0, 3'd2, 32'h0, 1'b1, 2'b01, 32'h0);
        busCycle("wrap_wait", 1'b1, 2'b00, 32'h8000_0000, 1'b0, 3'd2, 32'h0, 1'b0, 2'b00, 32'h0);
        busCycle("wrap_data", 1'b1, 2'b00, 32'h8000_0000, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0000_AB00);

        // Zero wait state build: SEQ burst of writes, then of reads
        dut_sel = 2'd1;
        busCycle("zw_wr_a0", 1'b1, 2'b10, 32'h8000_0020, 1'b1, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("zw_wr_d0", 1'b1, 2'b11, 32'h8000_0024, 1'b1, 3'd2, 32'h0101_0101, 1'b1, 2'b00, 32'h0);
        busCycle("zw_wr_d1", 1'b1, 2'b11, 32'h8000_0028, 1'b1, 3'd2, 32'h2323_4545, 1'b1, 2'b00, 32'h0);
        busCycle("zw_wr_d2", 1'b1, 2'b11, 32'h8000_002C, 1'b1, 3'd2, 32'h6789_ABCD, 1'b1, 2'b00, 32'h0);
        busCycle("zw_wr_d3", 1'b1, 2'b00, 32'h8000_002C, 1'b1, 3'd2, 32'hF00D_FACE, 1'b1, 2'b00, 32'h0);
        busCycle("zw_rd_a0", 1'b1, 2'b10, 32'h8000_0020, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("zw_rd_d0", 1'b1, 2'b11, 32'h8000_0024, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0101_0101);
        busCycle("zw_rd_d1", 1'b1, 2'b11, 32'h8000_0028, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h2323_4545);
        busCycle("zw_rd_d2", 1'b1, 2'b11, 32'h8000_002C, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'h6789_ABCD);
        busCycle("zw_rd_d3", 1'b1, 2'b00, 32'h8000_002C, 1'b0, 3'd2, 32'h0, 1'b1, 2'b00, 32'hF00D_FACE);

        // Three wait state build: reset aborts a write during its second wait cycle
        dut_sel = 2'd2;
        doXfer("w3_init", 1'b1, 32'h8000_0030, 3'd2, 32'hAAAA_5555, 32'h0, 3);
        busCycle("abort_addr", 1'b1, 2'b10, 32'h8000_0030, 1'b1, 3'd2, 32'h0, 1'b1, 2'b00, 32'h0);
        busCycle("abort_wait1", 1'b1, 2'b00, 32'h8000_0030, 1'b1, 3'd2, 32'h1234_5678, 1'b0, 2'b00, 32'h0);
        hreset = 1'b1;
        busCycle("abort_wait2", 1'b1, 2'b00, 32'h8000_0030, 1'b1, 3'd2, 32'h1234_5678, 1'b0, 2'b00, 32'h0);
        hreset = 1'b0;
        busCycle("abort_after", 1'b1, 2'b00, 32'h8000_0030, 1'b1, 3'd2, 32'h1234_5678, 1'b1, 2'b00, 32'h0);
        doXfer("abort_rd", 1'b0, 32'h8000_0030, 3'd2, 32'h0, 32'hAAAA_5555, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
